period_cnt: RTL

Front-end period meter that sits directly upstream of the cascaded low-pass smoother and supplies its data input and enable strobe.
- Synchronises an asynchronous square wave (oscillator output), detects rising edges, and counts clk_i cycles spanning CYCLES complete periods.
- Emits each completed count as one sample with a single-cycle valid strobe.
- Dead or too-slow inputs produce a saturated sample, so the downstream filter never stalls.

---
 rtl/period_cnt.sv | 111 +++++++++++
 1 files changed

// File: rtl/period_cnt.sv
// Period meter: synchronises an async square wave, counts clk_i cycles across
// CYCLES rising edges and emits one saturating sample per window with a strobe.
module period_cnt #(
  parameter int DATA_W = 32,
  parameter int CYCLES = 4,
  parameter int SYNC_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sq_i,
  output logic [DATA_W-1:0] data_o,
  output logic              en_o
);

  localparam int                EC_W    = $clog2(CYCLES + 1);
  localparam logic [EC_W-1:0]   EC_LAST = EC_W'(CYCLES - 1);
  localparam logic [DATA_W-1:0] CNT_SAT = {{(DATA_W-1){1'b1}}, 1'b0};
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    MEAS = 2'd2
  } state_t;

  logic [SYNC_W-1:0] sync_q;
  logic              delay_q;
  logic              edge_q;
  state_t            state_q;
  logic [DATA_W-1:0] cnt_q;
  logic [EC_W-1:0]   edge_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              en_q;
  logic              win_done;
  logic              sat_hit;

  // A completing edge in the saturation cycle wins, giving the normal 2^DATA_W-1.
  assign win_done = edge_q & (edge_cnt_q == EC_LAST);
  assign sat_hit  = (cnt_q == CNT_SAT) & ~win_done;

  // Synchroniser, edge detector, measurement FSM and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= {SYNC_W{1'b0}};
      delay_q    <= 1'b0;
      edge_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= {DATA_W{1'b0}};
      edge_cnt_q <= {EC_W{1'b0}};
      data_q     <= {DATA_W{1'b0}};
      en_q       <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_W-2:0], sq_i};
      delay_q <= sync_q[SYNC_W-1];
      edge_q  <= sync_q[SYNC_W-1] & ~delay_q;
      en_q    <= 1'b0;
      if (!en_i) begin
        state_q    <= IDLE;
        cnt_q      <= {DATA_W{1'b0}};
        edge_cnt_q <= {EC_W{1'b0}};
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q      <= {DATA_W{1'b0}};
            edge_cnt_q <= {EC_W{1'b0}};
            if (edge_q) begin
              state_q <= SKIP;
            end else begin
              state_q <= IDLE;
            end
          end
          SKIP, MEAS: begin
            if (win_done) begin
              // The completing edge also starts the next window.
              cnt_q      <= {DATA_W{1'b0}};
              edge_cnt_q <= {EC_W{1'b0}};
              state_q    <= MEAS;
              if (state_q == MEAS) begin
                data_q <= cnt_q + ONE;
                en_q   <= 1'b1;
              end
            end else if (sat_hit) begin
              cnt_q      <= {DATA_W{1'b0}};
              edge_cnt_q <= {EC_W{1'b0}};
              state_q    <= IDLE;
              if (state_q == MEAS) begin
                data_q <= {DATA_W{1'b1}};
                en_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + ONE;
              if (edge_q) begin
                edge_cnt_q <= edge_cnt_q + EC_W'(1);
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            cnt_q      <= {DATA_W{1'b0}};
            edge_cnt_q <= {EC_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign data_o = data_q;
  assign en_o   = en_q;

endmodule
